clint_axi_adapter: RTL and testbench



---
 rtl/clint_axi_adapter.sv | 199 +++++++++++++++++++
 tb/tb_clint_axi_adapter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clint_axi_adapter.sv
// AXI4 slave front-end for the core-local interrupt controller register strobe port.
// Single-beat accesses only; partial strobes become read-modify-write, bursts get SLVERR.
module clint_axi_adapter #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [ID_WIDTH-1:0]     aw_id_i,
  input  logic [7:0]              aw_len_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_last_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]              b_resp_o,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [ID_WIDTH-1:0]     ar_id_i,
  input  logic [7:0]              ar_len_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [DATA_WIDTH-1:0]   r_data_o,
  output logic [ID_WIDTH-1:0]     r_id_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  output logic [ADDR_WIDTH-1:0]   address_o,
  output logic                    en_o,
  output logic                    we_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  input  logic [DATA_WIDTH-1:0]   data_i
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RD_ACC, RD_RESP, WR_MERGE, WR_ACC, WR_DRAIN, WR_RESP, RD_ERR
  } state_t;

  state_t                r_state, w_state_next;
  logic                  r_prefer_wr, w_prefer_wr;
  logic [7:0]            r_cnt, w_cnt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb, w_wstrb;

  logic                  w_rd_req, w_wr_req, w_grant_rd, w_grant_wr;
  logic                  w_en, w_we, w_r_last;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data, w_r_data;
  logic [ID_WIDTH-1:0]   w_b_id, w_r_id;
  logic [1:0]            w_b_resp, w_r_resp;

  // Alternating arbitration; the flag only matters when both sides are waiting.
  assign w_rd_req   = (r_state == IDLE) && ar_valid_i;
  assign w_wr_req   = (r_state == IDLE) && aw_valid_i && w_valid_i;
  assign w_grant_rd = w_rd_req && (!w_wr_req || !r_prefer_wr);
  assign w_grant_wr = w_wr_req && (!w_rd_req || r_prefer_wr);
  assign ar_ready_o = w_grant_rd;
  assign aw_ready_o = w_grant_wr;
  assign w_ready_o  = w_grant_wr || (r_state == WR_DRAIN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_rd) begin
          w_state_next = (ar_len_i == 8'd0) ? RD_ACC : RD_ERR;
        end else if (w_grant_wr) begin
          if (aw_len_i != 8'd0)                     w_state_next = w_last_i ? WR_RESP : WR_DRAIN;
          else if (w_strb_i == {STRB_WIDTH{1'b1}})  w_state_next = WR_ACC;
          else if (w_strb_i == {STRB_WIDTH{1'b0}})  w_state_next = WR_RESP;
          else                                      w_state_next = WR_MERGE;
        end
      end
      RD_ACC:   w_state_next = RD_RESP;
      RD_RESP:  if (r_ready_i) w_state_next = IDLE;
      RD_ERR:   if (r_ready_i && r_cnt == 8'd0) w_state_next = IDLE;
      WR_MERGE: w_state_next = WR_ACC;
      WR_ACC:   w_state_next = WR_RESP;
      WR_DRAIN: if (w_valid_i && w_last_i) w_state_next = WR_RESP;
      WR_RESP:  if (b_ready_i) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // Next values for every registered output and the datapath holding registers.
  always_comb begin
    w_en        = 1'b0;
    w_we        = 1'b0;
    w_addr      = address_o;
    w_data      = data_o;
    w_b_id      = b_id_o;
    w_b_resp    = b_resp_o;
    w_r_data    = r_data_o;
    w_r_id      = r_id_o;
    w_r_resp    = r_resp_o;
    w_cnt       = r_cnt;
    w_wdata     = r_wdata;
    w_wstrb     = r_wstrb;
    w_prefer_wr = r_prefer_wr;
    case (r_state)
      IDLE: begin
        if (w_rd_req && w_wr_req) w_prefer_wr = ~r_prefer_wr;
        if (w_grant_rd) begin
          w_r_id = ar_id_i;
          w_cnt  = ar_len_i;
          if (ar_len_i == 8'd0) begin
            w_en     = 1'b1;
            w_addr   = ar_addr_i;
            w_r_resp = RESP_OKAY;
          end else begin
            w_r_data = '0;
            w_r_resp = RESP_SLVERR;
          end
        end else if (w_grant_wr) begin
          w_b_id  = aw_id_i;
          w_wdata = w_data_i;
          w_wstrb = w_strb_i;
          if (aw_len_i != 8'd0) begin
            w_b_resp = RESP_SLVERR;
          end else begin
            w_b_resp = RESP_OKAY;
            if (w_strb_i != {STRB_WIDTH{1'b0}}) begin
              w_en   = 1'b1;
              w_addr = aw_addr_i;
              if (w_strb_i == {STRB_WIDTH{1'b1}}) begin
                w_we   = 1'b1;
                w_data = w_data_i;
              end
            end
          end
        end
      end
      RD_ACC: w_r_data = data_i;
      RD_ERR: if (r_ready_i && r_cnt != 8'd0) w_cnt = r_cnt - 8'd1;
      WR_MERGE: begin
        w_en = 1'b1;
        w_we = 1'b1;
        for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
          w_data[8*i +: 8] = r_wstrb[i] ? r_wdata[8*i +: 8] : data_i[8*i +: 8];
        end
      end
      default: ;
    endcase
    w_r_last = (w_state_next == RD_RESP) || ((w_state_next == RD_ERR) && (w_cnt == 8'd0));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_o        <= 1'b0;
      we_o        <= 1'b0;
      address_o   <= '0;
      data_o      <= '0;
      b_valid_o   <= 1'b0;
      b_id_o      <= '0;
      b_resp_o    <= 2'b00;
      r_valid_o   <= 1'b0;
      r_data_o    <= '0;
      r_id_o      <= '0;
      r_resp_o    <= 2'b00;
      r_last_o    <= 1'b0;
      r_cnt       <= 8'd0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_prefer_wr <= 1'b0;
    end else begin
      en_o        <= w_en;
      we_o        <= w_we;
      address_o   <= w_addr;
      data_o      <= w_data;
      b_valid_o   <= (w_state_next == WR_RESP);
      b_id_o      <= w_b_id;
      b_resp_o    <= w_b_resp;
      r_valid_o   <= (w_state_next == RD_RESP) || (w_state_next == RD_ERR);
      r_data_o    <= w_r_data;
      r_id_o      <= w_r_id;
      r_resp_o    <= w_r_resp;
      r_last_o    <= w_r_last;
      r_cnt       <= w_cnt;
      r_wdata     <= w_wdata;
      r_wstrb     <= w_wstrb;
      r_prefer_wr <= w_prefer_wr;
    end
  end
endmodule

// File: tb/tb_clint_axi_adapter.sv
// Directed bench for clint_axi_adapter: inputs change 1 time unit after the rising edge,
// outputs are sampled in the same window.
module tb_clint_axi_adapter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aw_valid = 0, aw_ready, w_valid = 0, w_ready, w_last = 0;
  logic [63:0] aw_addr = '0, ar_addr = '0, w_data = '0, address, wr_data, rd_data = '0, r_data;
  logic [9:0]  aw_id = '0, ar_id = '0, b_id, r_id;
  logic [7:0]  aw_len = '0, ar_len = '0, w_strb = '0;
  logic        b_valid, b_ready = 0, ar_valid = 0, ar_ready, r_valid, r_ready = 0, r_last;
  logic [1:0]  b_resp, r_resp;
  logic        en, we;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  clint_axi_adapter dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr), .aw_id_i(aw_id), .aw_len_i(aw_len),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr), .ar_id_i(ar_id), .ar_len_i(ar_len),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data), .r_id_o(r_id), .r_resp_o(r_resp), .r_last_o(r_last),
    .address_o(address), .en_o(en), .we_o(we), .data_o(wr_data), .data_i(rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    #1;
    checks++; if ({ar_ready, aw_ready, w_ready, b_valid, r_valid} !== 5'b0) begin errors++; $display("FAIL reset_handshake: got %b want 00000", {ar_ready, aw_ready, w_ready, b_valid, r_valid}); end
    checks++; if ({en, we} !== 2'b00) begin errors++; $display("FAIL reset_strobe: got %b want 00", {en, we}); end
    checks++; if ({address, wr_data} !== 128'h0) begin errors++; $display("FAIL reset_addr_data: got %h %h want 0 0", address, wr_data); end
    checks++; if ({b_resp, b_id, r_resp, r_id, r_last} !== 25'h0) begin errors++; $display("FAIL reset_resp: got %h want 0", {b_resp, b_id, r_resp, r_id, r_last}); end
    checks++; if (r_data !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", r_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    ar_valid = 1; ar_addr = 64'hbff8; ar_id = 10'd5; ar_len = 8'd0;
    #1;
    checks++; if ({ar_ready, aw_ready} !== 2'b10) begin errors++; $display("FAIL rd_ar_ready: got %b want 10", {ar_ready, aw_ready}); end
    tick();
    ar_valid = 0; rd_data = 64'h1234_5678_9abc_def0;
    checks++; if ({en, we, address} !== {2'b10, 64'hbff8}) begin errors++; $display("FAIL rd_access: got %b %h want 10 bff8", {en, we}, address); end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rd_early_valid: got %b want 0", r_valid); end
    tick();
    rd_data = '0;
    checks++; if ({r_valid, r_data, r_id, r_resp, r_last} !== {1'b1, 64'h1234_5678_9abc_def0, 10'd5, 2'b00, 1'b1}) begin
      errors++; $display("FAIL rd_beat: got v=%b d=%h id=%0d resp=%b last=%b want v=1 d=123456789abcdef0 id=5 resp=00 last=1", r_valid, r_data, r_id, r_resp, r_last); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL rd_en_one_cycle: got %b want 0", en); end
    r_ready = 1;
    tick();
    r_ready = 0;
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rd_done: got %b want 0", r_valid); end
  endtask

  task automatic test_partial_write();
    aw_valid = 1; w_valid = 1; aw_addr = 64'h4000; aw_id = 10'd9; aw_len = 8'd0;
    w_data = 64'hAAAA_BBBB_CCCC_DDDD; w_strb = 8'h0F; w_last = 1;
    #1;
    checks++; if ({aw_ready, w_ready} !== 2'b11) begin errors++; $display("FAIL pw_ready: got %b want 11", {aw_ready, w_ready}); end
    tick();
    aw_valid = 0; w_valid = 0; rd_data = 64'h1111_2222_3333_4444;
    checks++; if ({en, we, address} !== {2'b10, 64'h4000}) begin errors++; $display("FAIL pw_merge_read: got %b %h want 10 4000", {en, we}, address); end
    tick();
    rd_data = '0;
    checks++; if ({en, we, wr_data} !== {2'b11, 64'h1111_2222_CCCC_DDDD}) begin errors++; $display("FAIL pw_write: got %b %h want 11 11112222ccccdddd", {en, we}, wr_data); end
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL pw_early_b: got %b want 0", b_valid); end
    tick();
    checks++; if ({b_valid, b_resp, b_id, en} !== {1'b1, 2'b00, 10'd9, 1'b0}) begin errors++; $display("FAIL pw_b: got v=%b resp=%b id=%0d en=%b want 1 00 9 0", b_valid, b_resp, b_id, en); end
    b_ready = 1;
    tick();
    b_ready = 0;
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL pw_done: got %b want 0", b_valid); end
  endtask

  task automatic test_contested();
    do_reset();
    ar_valid = 1; ar_addr = 64'h8; ar_id = 10'd1; ar_len = 0;
    aw_valid = 1; w_valid = 1; aw_addr = 64'h4008; aw_id = 10'd2; aw_len = 0;
    w_data = 64'h0102_0304_0506_0708; w_strb = 8'hFF;
    #1;
    checks++; if ({ar_ready, aw_ready, w_ready} !== 3'b100) begin errors++; $display("FAIL contest1: got %b want 100", {ar_ready, aw_ready, w_ready}); end
    tick();
    ar_valid = 0;
    #1;
    checks++; if ({aw_ready, w_ready} !== 2'b00) begin errors++; $display("FAIL contest_busy: got %b want 00", {aw_ready, w_ready}); end
    tick();
    r_ready = 1;
    tick();
    r_ready = 0; ar_valid = 1; ar_id = 10'd3;
    #1;
    checks++; if ({ar_ready, aw_ready, w_ready} !== 3'b011) begin errors++; $display("FAIL contest2: got %b want 011", {ar_ready, aw_ready, w_ready}); end
    tick();
    aw_valid = 0; w_valid = 0;
    checks++; if ({en, we, address, wr_data} !== {2'b11, 64'h4008, 64'h0102_0304_0506_0708}) begin errors++; $display("FAIL full_write: got %b %h %h want 11 4008 0102030405060708", {en, we}, address, wr_data); end
    tick();
    checks++; if ({b_valid, b_id, ar_ready} !== {1'b1, 10'd2, 1'b0}) begin errors++; $display("FAIL full_write_b: got %b %0d %b want 1 2 0", b_valid, b_id, ar_ready); end
    b_ready = 1;
    tick();
    b_ready = 0; aw_valid = 1; w_valid = 1;
    #1;
    checks++; if ({ar_ready, aw_ready, w_ready} !== 3'b100) begin errors++; $display("FAIL contest3: got %b want 100", {ar_ready, aw_ready, w_ready}); end
    tick();
    ar_valid = 0; aw_valid = 0; w_valid = 0;
    tick();
    checks++; if ({r_valid, r_id} !== {1'b1, 10'd3}) begin errors++; $display("FAIL contest3_beat: got %b %0d want 1 3", r_valid, r_id); end
    r_ready = 1;
    tick();
    r_ready = 0;
  endtask

  task automatic test_burst_write();
    int hs = 0;
    int en_seen = 0;
    aw_valid = 1; w_valid = 1; aw_addr = 64'h4000; aw_id = 10'd4; aw_len = 8'd3; w_strb = 8'hFF; w_last = 0;
    for (int i = 0; i < 4; i++) begin
      w_data = 64'(i + 1); w_last = (i == 3);
      #1;
      if (w_valid && w_ready) hs++;
      tick();
      aw_valid = 0;
      if (en) en_seen++;
    end
    w_valid = 0; w_last = 0;
    checks++; if (hs !== 4) begin errors++; $display("FAIL bw_handshakes: got %0d want 4", hs); end
    checks++; if (en_seen !== 0) begin errors++; $display("FAIL bw_no_access: got %0d en cycles want 0", en_seen); end
    checks++; if ({b_valid, b_resp, b_id, w_ready} !== {1'b1, 2'b10, 10'd4, 1'b0}) begin errors++; $display("FAIL bw_b: got v=%b resp=%b id=%0d wr=%b want 1 10 4 0", b_valid, b_resp, b_id, w_ready); end
    b_ready = 1;
    tick();
    b_ready = 0;
  endtask

  task automatic test_burst_read();
    ar_valid = 1; ar_addr = 64'h10; ar_id = 10'd7; ar_len = 8'd2;
    tick();
    ar_valid = 0; r_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({r_valid, r_data, r_resp, r_id, r_last, en} !== {1'b1, 64'h0, 2'b10, 10'd7, (i == 2), 1'b0}) begin
        errors++; $display("FAIL br_beat%0d: got v=%b d=%h resp=%b id=%0d last=%b en=%b want 1 0 10 7 %0d 0", i, r_valid, r_data, r_resp, r_id, r_last, en, (i == 2)); end
      tick();
    end
    r_ready = 0;
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL br_done: got %b want 0", r_valid); end
  endtask

  task automatic test_backpressure_reset();
    ar_valid = 1; ar_addr = 64'h20; ar_id = 10'd6; ar_len = 0;
    tick();
    rd_data = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    rd_data = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({r_valid, r_data, r_id, r_last, ar_ready} !== {1'b1, 64'hDEAD_BEEF_0BAD_F00D, 10'd6, 1'b1, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d last=%b arr=%b want 1 deadbeef0badf00d 6 1 0", i, r_valid, r_data, r_id, r_last, ar_ready); end
      tick();
    end
    ar_valid = 0;
    rst = 1;
    #1;
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rst_async: got %b want 0", r_valid); end
    tick();
    rst = 0;
    r_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rst_no_beat%0d: got %b want 0", i, r_valid); end
    end
    r_ready = 0;
  endtask

  task automatic test_zero_strobe();
    aw_valid = 1; w_valid = 1; aw_addr = 64'h4000; aw_id = 10'd8; aw_len = 0; w_strb = 8'h00; w_data = '1;
    #1;
    checks++; if ({aw_ready, w_ready} !== 2'b11) begin errors++; $display("FAIL zs_ready: got %b want 11", {aw_ready, w_ready}); end
    tick();
    aw_valid = 0; w_valid = 0;
    checks++; if ({en, b_valid, b_resp, b_id} !== {1'b0, 1'b1, 2'b00, 10'd8}) begin errors++; $display("FAIL zs_b: got en=%b v=%b resp=%b id=%0d want 0 1 00 8", en, b_valid, b_resp, b_id); end
    b_ready = 1;
    tick();
    b_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_partial_write();
    test_contested();
    test_burst_write();
    test_burst_read();
    test_zero_strobe();
    test_backpressure_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
